// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer for the HI/LO unit.
// Runs MULT/MULTU as shift-add and DIV/DIVU as restoring divide on operand
// magnitudes, one bit per cycle, then fixes signs and writes HI/LO.
//
// state  | meaning
// S_IDLE | waiting for start; latches magnitudes and result signs
// S_RUN  | WIDTH iterations, one bit per cycle
// S_FIX  | sign correction; HI/LO and done written on the way out
// S_DONE | done pulse visible, busy low; back to idle
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] upper_q;  // accumulator or partial remainder
  logic [WIDTH-1:0] lower_q;  // multiplier or quotient
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  // Start-cycle operand decode: op[1] selects divide, op[0]=0 means signed.
  logic             is_div_in;
  logic             a_neg_d;
  logic             b_neg_d;
  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;

  assign is_div_in = op[1];
  assign a_neg_d   = ~op[0] & a[WIDTH-1];
  assign b_neg_d   = ~op[0] & b[WIDTH-1];
  // |-2^(W-1)| comes out as 2^(W-1) read unsigned, which is what the loop needs.
  assign a_mag_d   = a_neg_d ? (~a + 1'b1) : a;
  assign b_mag_d   = b_neg_d ? (~b + 1'b1) : b;

  // Multiply step: WIDTH+1-bit sum keeps the carry that shifts into acc MSB.
  logic [WIDTH:0] mul_sum_d;
  assign mul_sum_d = {1'b0, upper_q} + (lower_q[0] ? {1'b0, opnd_q} : '0);

  // Divide step: shifted remainder is WIDTH+1 bits; when it is >= divisor the
  // difference is below the divisor, so a WIDTH-bit subtract is exact.
  logic [WIDTH:0]   div_shift_d;
  logic             div_ge_d;
  logic [WIDTH-1:0] div_diff_d;
  assign div_shift_d = {upper_q, lower_q[WIDTH-1]};
  assign div_ge_d    = div_shift_d >= {1'b0, opnd_q};
  assign div_diff_d  = div_shift_d[WIDTH-1:0] - opnd_q;

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] prod_fix_d;
  logic [WIDTH-1:0]   quo_fix_d;
  logic [WIDTH-1:0]   rem_fix_d;
  assign prod_d     = {upper_q, lower_q};
  assign prod_fix_d = neg_res_q ? (~prod_d + 1'b1) : prod_d;
  assign quo_fix_d  = neg_res_q ? (~lower_q + 1'b1) : lower_q;
  assign rem_fix_d  = neg_rem_q ? (~upper_q + 1'b1) : upper_q;

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      upper_q   <= '0;
      lower_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (is_div_in && (b == '0)) begin
              hi_q    <= a;
              lo_q    <= '1;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              is_div_q  <= is_div_in;
              neg_res_q <= a_neg_d ^ b_neg_d;
              neg_rem_q <= a_neg_d;
              upper_q   <= '0;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= S_RUN;
              if (is_div_in) begin
                opnd_q  <= b_mag_d;
                lower_q <= a_mag_d;
              end else begin
                opnd_q  <= a_mag_d;
                lower_q <= b_mag_d;
              end
            end
          end
        end
        S_RUN: begin
          if (is_div_q) begin
            if (div_ge_d) begin
              upper_q <= div_diff_d;
              lower_q <= {lower_q[WIDTH-2:0], 1'b1};
            end else begin
              upper_q <= div_shift_d[WIDTH-1:0];
              lower_q <= {lower_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            upper_q <= mul_sum_d[WIDTH:1];
            lower_q <= {mul_sum_d[0], lower_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (is_div_q) begin
            hi_q <= rem_fix_d;
            lo_q <= quo_fix_d;
          end else begin
            hi_q <= prod_fix_d[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix_d[WIDTH-1:0];
          end
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a vector table of ops with hand-computed
// HI/LO/flag/latency values, plus sequences for start-during-run and reset abort.
module tb_muldiv_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total;
  int bad;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dbz;
    int           exp_lat;
    int           exp_busy;
  } vec_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Start one op in the next idle cycle; report cycles to done and busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  int lat;
  int bcnt;
  logic [W-1:0] prev_hi;
  logic [W-1:0] prev_lo;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;

    vecs.push_back('{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 33});
    vecs.push_back('{"mult_neg3x7", OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 33});
    vecs.push_back('{"div_m7_2",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33});
    vecs.push_back('{"divu_7_2",    OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 34, 33});
    vecs.push_back('{"divu_by0",    OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1, 0});
    vecs.push_back('{"multu_3x5",   OP_MULTU, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0, 34, 33});
    vecs.push_back('{"div_min_m1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 33});
    vecs.push_back('{"mult_minsq",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 33});
    vecs.push_back('{"div_7_m2",    OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 33});
    vecs.push_back('{"div_m7_m2",   OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 34, 33});
    vecs.push_back('{"mult_x_m1",   OP_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0, 34, 33});
    vecs.push_back('{"div_by0_s",   OP_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1, 0});
    vecs.push_back('{"div_0_5",     OP_DIV,   32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 34, 33});
    vecs.push_back('{"multu_2p32",  OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 34, 33});
    vecs.push_back('{"divu_big_16", OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 34, 33});
    vecs.push_back('{"multu_unsgn", OP_MULTU, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB, 1'b0, 34, 33});

    // Reset state.
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
    check("rst_hi",   hi, 32'd0);
    check("rst_lo",   lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven ops, issued back-to-back in the cycle after each done.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      check({vecs[i].name, "_lat"},  lat, vecs[i].exp_lat);
      check({vecs[i].name, "_busy"}, bcnt, vecs[i].exp_busy);
      check({vecs[i].name, "_hi"},   hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"},   lo, vecs[i].exp_lo);
      check({vecs[i].name, "_dbz"},  {31'd0, div_by_zero}, {31'd0, vecs[i].exp_dbz});
      @(posedge clk);
      #1;
      check({vecs[i].name, "_pulse"}, {31'd0, done}, 32'd0);
      check({vecs[i].name, "_hold"},  lo, vecs[i].exp_lo);
    end

    // start pulsed during RUN is ignored; hi/lo hold until done.
    prev_hi = hi;
    prev_lo = lo;
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIV;
    a     = 32'h80000000;
    b     = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    op    = OP_MULTU;
    a     = 32'h00000009;
    b     = 32'h00000009;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_hi_mid", hi, prev_hi);
    check("ign_lo_mid", lo, prev_lo);
    check("ign_busy_mid", {31'd0, busy}, 32'd1);
    lat = 9;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ign_lat", lat, 34);
    check("ign_hi",  hi, 32'h00000000);
    check("ign_lo",  lo, 32'h80000000);
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    check("ign_no_restart", {31'd0, busy}, 32'd0);

    // Reset dropped at RUN iteration 10 of a MULT aborts it immediately.
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'h00001234;
    b     = 32'hFFFF0003;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi",   hi, 32'd0);
    check("abort_lo",   lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(OP_MULTU, 32'h00000003, 32'h00000005, lat, bcnt);
    check("post_rst_lat", lat, 34);
    check("post_rst_hi",  hi, 32'h00000000);
    check("post_rst_lo",  lo, 32'h0000000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
